// File: rtl/alu_rs_scheduler.sv
// Reservation station and single-issue scheduler for the integer ALU; wakes operands from the CDB.
// Optional RS_CDB_BYPASS_EN lets a dispatch capture a same-edge CDB broadcast for its waiting operands.
module alu_rs_scheduler #(
    parameter int RS_SIZE  = 16,
    parameter int RS_IDX_W = 4,
    parameter int OP_W     = 6,
    parameter int DATA_W   = 32,
    parameter int TAG_W    = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                rdy,
    input  logic                in_flush,
    input  logic                in_disp_valid,
    input  logic [OP_W-1:0]     in_disp_op,
    input  logic                in_disp_rs1_rdy,
    input  logic [DATA_W-1:0]   in_disp_rs1_val,
    input  logic [TAG_W-1:0]    in_disp_rs1_tag,
    input  logic                in_disp_rs2_rdy,
    input  logic [DATA_W-1:0]   in_disp_rs2_val,
    input  logic [TAG_W-1:0]    in_disp_rs2_tag,
    input  logic [DATA_W-1:0]   in_disp_imm,
    input  logic [DATA_W-1:0]   in_disp_pc,
    input  logic [TAG_W-1:0]    in_disp_rob_tag,
    output logic                out_full,
    output logic [RS_IDX_W:0]   out_count,
    input  logic                in_cdb_valid,
    input  logic [TAG_W-1:0]    in_cdb_tag,
    input  logic [DATA_W-1:0]   in_cdb_value,
    output logic                out_alu_valid,
    output logic [OP_W-1:0]     out_alu_op,
    output logic [DATA_W-1:0]   out_alu_rs1,
    output logic [DATA_W-1:0]   out_alu_rs2,
    output logic [DATA_W-1:0]   out_alu_imm,
    output logic [DATA_W-1:0]   out_alu_pc,
    output logic [TAG_W-1:0]    out_alu_rob_tag
);

    localparam int CNT_W = RS_IDX_W + 1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [RS_SIZE-1:0]  busy;
    logic [RS_SIZE-1:0]  q1_wait;
    logic [RS_SIZE-1:0]  q2_wait;
    logic [OP_W-1:0]     op_q   [RS_SIZE];
    logic [DATA_W-1:0]   v1_q   [RS_SIZE];
    logic [DATA_W-1:0]   v2_q   [RS_SIZE];
    logic [DATA_W-1:0]   imm_q  [RS_SIZE];
    logic [DATA_W-1:0]   pc_q   [RS_SIZE];
    logic [TAG_W-1:0]    t1_q   [RS_SIZE];
    logic [TAG_W-1:0]    t2_q   [RS_SIZE];
    logic [TAG_W-1:0]    rob_q  [RS_SIZE];
    logic [CNT_W-1:0]    count;

    logic [RS_SIZE-1:0]  ready_vec;
    logic                free_hit;
    logic [RS_IDX_W-1:0] free_idx;
    logic                iss_hit;
    logic [RS_IDX_W-1:0] iss_idx;
    logic                disp_acc;
    logic                byp1;
    logic                byp2;
    logic                disp_q1;
    logic                disp_q2;
    logic [DATA_W-1:0]   disp_v1;
    logic [DATA_W-1:0]   disp_v2;
    logic [CNT_W-1:0]    count_nxt;

    logic                alu_valid_p1;
    logic [OP_W-1:0]     alu_op_p1;
    logic [DATA_W-1:0]   alu_rs1_p1;
    logic [DATA_W-1:0]   alu_rs2_p1;
    logic [DATA_W-1:0]   alu_imm_p1;
    logic [DATA_W-1:0]   alu_pc_p1;
    logic [TAG_W-1:0]    alu_rob_p1;

    assign out_full  = &busy;
    assign out_count = count;
    assign ready_vec = busy & ~q1_wait & ~q2_wait;
    assign disp_acc  = in_disp_valid && !out_full;

    // Lowest-index search for both the free slot and the issue winner.
    always_comb begin
        free_hit = 1'b0;
        free_idx = '0;
        iss_hit  = 1'b0;
        iss_idx  = '0;
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            if (!busy[i]) begin
                free_hit = 1'b1;
                free_idx = RS_IDX_W'(i);
            end
            if (ready_vec[i]) begin
                iss_hit = 1'b1;
                iss_idx = RS_IDX_W'(i);
            end
        end
    end

`ifdef RS_CDB_BYPASS_EN
    assign byp1 = !in_disp_rs1_rdy && in_cdb_valid && (in_cdb_tag == in_disp_rs1_tag);
    assign byp2 = !in_disp_rs2_rdy && in_cdb_valid && (in_cdb_tag == in_disp_rs2_tag);
`else
    assign byp1 = 1'b0;
    assign byp2 = 1'b0;
`endif

    assign disp_q1 = !in_disp_rs1_rdy && !byp1;
    assign disp_q2 = !in_disp_rs2_rdy && !byp2;
    assign disp_v1 = byp1 ? in_cdb_value : in_disp_rs1_val;
    assign disp_v2 = byp2 ? in_cdb_value : in_disp_rs2_val;

    always_comb begin
        count_nxt = count;
        if (disp_acc && !iss_hit) begin
            count_nxt = count + CNT_ONE;
        end else if (!disp_acc && iss_hit) begin
            count_nxt = count - CNT_ONE;
        end
    end

    // Control state: occupancy, wait flags, count and issue valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy         <= '0;
            q1_wait      <= '0;
            q2_wait      <= '0;
            count        <= '0;
            alu_valid_p1 <= 1'b0;
        end else if (rdy) begin
            if (in_flush) begin
                busy         <= '0;
                count        <= '0;
                alu_valid_p1 <= 1'b0;
            end else begin
                for (int i = 0; i < RS_SIZE; i++) begin
                    if (in_cdb_valid && busy[i] && q1_wait[i] && (t1_q[i] == in_cdb_tag)) begin
                        q1_wait[i] <= 1'b0;
                    end
                    if (in_cdb_valid && busy[i] && q2_wait[i] && (t2_q[i] == in_cdb_tag)) begin
                        q2_wait[i] <= 1'b0;
                    end
                end
                if (iss_hit) begin
                    busy[iss_idx] <= 1'b0;
                end
                if (disp_acc && free_hit) begin
                    busy[free_idx]    <= 1'b1;
                    q1_wait[free_idx] <= disp_q1;
                    q2_wait[free_idx] <= disp_q2;
                end
                alu_valid_p1 <= iss_hit;
                count        <= count_nxt;
            end
        end
    end

    // Entry payload; meaningful only while the matching busy bit is set.
    always_ff @(posedge clk) begin
        if (rdy && !in_flush) begin
            for (int i = 0; i < RS_SIZE; i++) begin
                if (in_cdb_valid && busy[i] && q1_wait[i] && (t1_q[i] == in_cdb_tag)) begin
                    v1_q[i] <= in_cdb_value;
                end
                if (in_cdb_valid && busy[i] && q2_wait[i] && (t2_q[i] == in_cdb_tag)) begin
                    v2_q[i] <= in_cdb_value;
                end
            end
            if (disp_acc && free_hit) begin
                op_q[free_idx]  <= in_disp_op;
                v1_q[free_idx]  <= disp_v1;
                v2_q[free_idx]  <= disp_v2;
                t1_q[free_idx]  <= in_disp_rs1_tag;
                t2_q[free_idx]  <= in_disp_rs2_tag;
                imm_q[free_idx] <= in_disp_imm;
                pc_q[free_idx]  <= in_disp_pc;
                rob_q[free_idx] <= in_disp_rob_tag;
            end
        end
    end

    // Issue stage register toward the ALU; fields hold when nothing issues.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_op_p1  <= '0;
            alu_rs1_p1 <= '0;
            alu_rs2_p1 <= '0;
            alu_imm_p1 <= '0;
            alu_pc_p1  <= '0;
            alu_rob_p1 <= '0;
        end else if (rdy && !in_flush && iss_hit) begin
            alu_op_p1  <= op_q[iss_idx];
            alu_rs1_p1 <= v1_q[iss_idx];
            alu_rs2_p1 <= v2_q[iss_idx];
            alu_imm_p1 <= imm_q[iss_idx];
            alu_pc_p1  <= pc_q[iss_idx];
            alu_rob_p1 <= rob_q[iss_idx];
        end
    end

    assign out_alu_valid   = alu_valid_p1;
    assign out_alu_op      = alu_op_p1;
    assign out_alu_rs1     = alu_rs1_p1;
    assign out_alu_rs2     = alu_rs2_p1;
    assign out_alu_imm     = alu_imm_p1;
    assign out_alu_pc      = alu_pc_p1;
    assign out_alu_rob_tag = alu_rob_p1;

endmodule
